// File: rtl/avalon_pio_ext_pkg.sv
// Shared constants for the Avalon-MM parallel I/O port: register word
// addresses and edge-detect mode encodings.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO: zero-wait-state reads, active-low
// write strobe qualified by chipselect.
//
// Handshake: a transfer happens in any cycle with chipselect high; it is a
// write when write_n is low, otherwise a read. There is no waitrequest: writes
// commit at the clock edge ending the cycle and readdata is valid in the same
// cycle the address is presented.
interface avalon_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_ext_sync_edge.sv
// Input synchroniser chain plus one history flop; emits the synchronised
// input and a per-bit edge strobe of the selected polarity.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  in_prev;

  // in_prev clears with the chain, so a pin held high through reset is
  // reported once as a rising edge after release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain   <= '0;
      in_prev <= '0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], in_port};
      in_prev <= chain[SYNC_STAGES-1];
    end
  end

  assign in_sync = chain[SYNC_STAGES-1];

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = in_sync & ~in_prev;
      EDGE_FALL: edge_det = ~in_sync & in_prev;
      default:   edge_det = in_sync ^ in_prev;
    endcase
  end

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O port: output data with atomic set/clear, per-bit
// direction, synchronised inputs, sticky edge capture and maskable level irq.
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  avalon_pio_ext_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic             wr;
  logic             unused_wdata;

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];
  // Bits above WIDTH are architecturally ignored.
  assign unused_wdata = ^bus.writedata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  assign cap_clr = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= OUT_RESET;
      dir      <= DIR_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          ADDR_DATA:     data_out <= wdata;
          ADDR_DIR:      dir      <= wdata;
          ADDR_IRQ_MASK: irq_mask <= wdata;
          ADDR_OUTSET:   data_out <= data_out | wdata;
          ADDR_OUTCLR:   data_out <= data_out & ~wdata;
          default:       ;
        endcase
      end
      // A new edge in the same cycle as its clear wins, so no event is lost.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:      bus.readdata[WIDTH-1:0] = dir;
      ADDR_IRQ_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: bus.readdata[WIDTH-1:0] = edge_cap;
      default:       bus.readdata = '0;
    endcase
  end

  assign out_port = data_out;
  assign out_en   = dir;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed bench for avalon_pio_ext: register-access vector table plus
// hand-timed sequences for synchroniser latency, clear/edge races and reset.
module tb_avalon_pio_ext;
  import avalon_pio_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic [W-1:0] out_en;
  logic         irq;

  avalon_pio_ext_if bus ();

  avalon_pio_ext #(
    .WIDTH       (W),
    .OUT_RESET   (8'hA5),
    .DIR_RESET   (8'hFF),
    .EDGE_TYPE   (EDGE_RISE),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .out_en   (out_en),
    .irq      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]   waddr;
    logic [31:0]  wdata;
    logic [2:0]   raddr;
    logic [31:0]  exp_rd;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic bus_idle();
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus_idle();
  endtask

  // scoreboard: expected read value is queued, then matched against the bus
  task automatic expect_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    bus_read(a, got);
    check(name, got, exp_q.pop_front());
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{ADDR_DATA,   32'h0000_000F, ADDR_DATA,   32'h0000_000F, 8'h0F};
    vecs[1] = '{ADDR_OUTSET, 32'h0000_0030, ADDR_OUTSET, 32'h0000_0000, 8'h3F};
    vecs[2] = '{ADDR_OUTCLR, 32'h0000_0001, ADDR_OUTCLR, 32'h0000_0000, 8'h3E};
    vecs[3] = '{ADDR_DATA,   32'hFFFF_FFFF, ADDR_DATA,   32'h0000_00FF, 8'hFF};
    vecs[4] = '{ADDR_DIR,    32'h0000_00F0, ADDR_DIR,    32'h0000_00F0, 8'hFF};
    vecs[5] = '{ADDR_DATA,   32'h0000_00AA, ADDR_DATA,   32'h0000_00A0, 8'hAA};

    bus_idle();
    in_port = '0;
    reset_n = 1'b0;
    wait_edges(3);
    reset_n = 1'b1;
    wait_edges(1);

    check("reset out_port", 32'(out_port), 32'hA5);
    check("reset out_en",   32'(out_en),   32'hFF);
    check("reset irq",      32'(irq),      32'h0);
    expect_rd("reset irq_mask", ADDR_IRQ_MASK, 32'h0);

    foreach (vecs[i]) begin
      bus_write(vecs[i].waddr, vecs[i].wdata);
      check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
      expect_rd($sformatf("vec%0d readdata", i), vecs[i].raddr, vecs[i].exp_rd);
    end

    // mixed-direction read: high nibble from data_out, low nibble from pins
    in_port = 8'h05;
    wait_edges(3);
    expect_rd("mixed dir read", ADDR_DATA, 32'h0000_00A5);
    expect_rd("edge_cap after 0->05", ADDR_EDGE_CAP, 32'h05);
    check("irq masked off", 32'(irq), 32'h0);
    bus_write(ADDR_EDGE_CAP, 32'hFF);
    expect_rd("edge_cap cleared", ADDR_EDGE_CAP, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h01);
    expect_rd("irq_mask readback", ADDR_IRQ_MASK, 32'h01);

    // falling edge is ignored in rising mode
    in_port = 8'h04;
    wait_edges(4);
    expect_rd("fall not captured", ADDR_EDGE_CAP, 32'h0);

    // latency: change just after edge 0, capture at edge 3
    in_port = 8'h05;
    wait_edges(1);
    check("irq edge1", 32'(irq), 32'h0);
    wait_edges(1);
    check("irq edge2", 32'(irq), 32'h0);
    wait_edges(1);
    check("irq edge3", 32'(irq), 32'h1);
    expect_rd("edge_cap edge3", ADDR_EDGE_CAP, 32'h01);
    bus_write(ADDR_EDGE_CAP, 32'h01);
    check("irq after clear", 32'(irq), 32'h0);

    // clear and new edge on the same bit in the same cycle
    in_port = 8'h04;
    wait_edges(4);
    in_port = 8'h05;
    wait_edges(2);
    bus.address    = ADDR_EDGE_CAP;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h01;
    wait_edges(1);
    bus_idle();
    expect_rd("race edge_cap", ADDR_EDGE_CAP, 32'h01);
    check("race irq", 32'(irq), 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'h01);
    check("race irq cleared", 32'(irq), 32'h0);

    // reserved addresses
    bus_write(3'd6, 32'hFFFF_FFFF);
    expect_rd("reserved 6", 3'd6, 32'h0);
    expect_rd("reserved 7", 3'd7, 32'h0);
    expect_rd("dir unchanged", ADDR_DIR, 32'hF0);
    check("out unchanged", 32'(out_port), 32'hAA);

    // reset overrides a concurrent write; input held high recaptures later
    @(posedge clk); #1;
    reset_n        = 1'b0;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h0000_0000;
    wait_edges(1);
    reset_n = 1'b1;
    bus_idle();
    check("rst-wr out_port", 32'(out_port), 32'hA5);
    check("rst-wr out_en",   32'(out_en),   32'hFF);
    check("rst-wr irq",      32'(irq),      32'h0);
    expect_rd("rst-wr irq_mask", ADDR_IRQ_MASK, 32'h0);
    expect_rd("rst-wr edge_cap", ADDR_EDGE_CAP, 32'h0);
    wait_edges(2);
    expect_rd("post-rst edge2", ADDR_EDGE_CAP, 32'h0);
    wait_edges(1);
    expect_rd("post-rst edge3", ADDR_EDGE_CAP, 32'h05);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_ext.md
# avalon_pio_ext

Parametrised Avalon-MM parallel I/O port for the Qsys system: a WIDTH-bit bidirectional-capable port with per-bit direction, atomic bit set/clear, synchronised inputs, edge capture and a maskable level interrupt. It sits on the Nios II data master alongside the existing single-bit control PIOs (IIC GO etc.) and replaces them where multiple bits, inputs or interrupts are needed.

## Interface
- WIDTH, 8: port width, 1..32.
- OUT_RESET, 0: reset value of the output data register (WIDTH bits).
- DIR_RESET, all ones: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- address  in  3  register word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data, combinational, zero-extended.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- out_en  out  WIDTH  direction register (per-bit output enable for tri-state pad).
- irq  out  1  level interrupt.

## Operation
- Write = chipselect & ~write_n. Register map (word address):
  - 0 DATA: write loads data_out; read returns per bit dir ? data_out : in_sync.
  - 1 DIR: read/write direction.
  - 2 IRQ_MASK: read/write interrupt mask.
  - 3 EDGE_CAP: read capture bits; write-1-to-clear.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write ANDs ~writedata into data_out; reads 0.
  - 6, 7: reserved; writes ignored, read 0.
- in_port passes through SYNC_STAGES flops to in_sync, plus one more flop in_prev for edge detection.
- Edge per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = xor.
- edge_cap[i] set on detected edge regardless of direction or mask; held until cleared.
- Simultaneous edge and write-1-to-clear on the same bit: set wins (edge never lost).
- irq = |(edge_cap & irq_mask), combinational from registers.
- Reset: out_port = OUT_RESET, out_en = DIR_RESET, irq_mask = 0, edge_cap = 0, synchroniser and in_prev = 0, irq = 0. Because in_prev resets to 0, an input held high through reset produces one rising capture SYNC_STAGES+1 cycles after reset release; this is required behaviour.
- Reset asserted mid-operation overrides any concurrent write in that cycle.

## Timing
- Writes take effect at the clk edge of the write cycle; out_port/out_en/irq_mask update visible next cycle.
- Reads: zero wait states, zero latency; readdata reflects register contents in the same cycle as address/chipselect.
- in_port change at edge 0 reaches in_sync after SYNC_STAGES edges; edge_cap and irq assert at edge SYNC_STAGES+1.
- irq deasserts the cycle after a clearing EDGE_CAP write or mask write removing the last enabled bit.
- Pulses on in_port shorter than one clk period may be missed; not required to capture.

## Structure
- Package avalon_pio_pkg: address constants ADDR_DATA..ADDR_OUTCLR, EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- Sub-module pio_sync_edge (WIDTH, SYNC_STAGES, EDGE_TYPE): synchroniser chain, in_prev, edge vector output. Top holds registers, read mux, irq.

## Test plan
- Reset with WIDTH=8, OUT_RESET=8'hA5 -> out_port=8'hA5, out_en=8'hFF, irq=0, read addr 2 = 0.
- Write DATA 8'h0F, OUTSET 8'h30, OUTCLR 8'h01 -> out_port 8'h0F, 8'h3F, 8'h3E on successive cycles; reads of addr 4/5 return 0.
- DIR=8'hF0, data_out=8'hAA, in_port=8'h05 stable -> DATA read 8'hA5.
- EDGE_TYPE=0, mask=8'h01, in_port[0] 0->1 -> edge_cap=8'h01 and irq=1 exactly 3 cycles later (SYNC_STAGES=2); write 8'h01 to addr 3 -> irq=0 next cycle.
- Same-cycle edge on bit 0 and write-1-to-clear bit 0 -> edge_cap[0] remains 1, irq stays asserted.
- Write 32'hFFFF_FFFF to DATA with WIDTH=8 -> out_port=8'hFF, readdata[31:8]=0; assert reset_n low during a write -> registers take reset values.
